// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack boot/program-load controller.
package hack_pkg;

  localparam int HACK_ADDR_W    = 15;
  localparam int HACK_DATA_W    = 16;
  localparam int HACK_ROM_WORDS = 32768;

  typedef enum logic [2:0] {
    S_SETTLE = 3'd0,
    S_RUN    = 3'd1,
    S_ENTER  = 3'd2,
    S_LOAD   = 3'd3,
    S_DRAIN  = 3'd4
  } boot_state_t;

  // True when a download byte address lands inside the 32K-word program store.
  function automatic logic in_rom(input logic [24:0] byte_addr);
    return byte_addr[24:1] < 24'(HACK_ROM_WORDS);
  endfunction

endpackage

// File: rtl/hack_reset_stretcher.sv
// Loadable down-counter that times the CPU reset hold.
// busy is low in the final hold cycle, so a hold that starts with the counter
// freshly loaded lasts exactly CYCLES cycles.
module hack_reset_stretcher #(
  parameter int CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  output logic busy
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  // Reload on request, otherwise count down to zero and stay there.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= CW'(CYCLES);
    end else if (load) begin
      count <= CW'(CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count > CW'(1));

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer and program-ROM port arbiter for the Hack computer.
// Download handshake: hps_io presents one word per single-cycle ioctl_wr while
// ioctl_download is high; ioctl_wait asks it to hold off (only in S_ENTER).
// Every accepted word becomes a one-cycle rom_we pulse in the next cycle.
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W        = HACK_ADDR_W,
  parameter int DATA_W        = HACK_DATA_W,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              user_reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              load_done,
  output logic [15:0]       word_count,
  output logic              overflow,
  output boot_state_t       state_dbg
);

  boot_state_t       state, next_state;
  logic              settle_load;
  logic              settle_busy;
  logic              accept;
  logic              wr_ok;
  logic [ADDR_W-1:0] cap_addr;

  hack_reset_stretcher #(.CYCLES(SETTLE_CYCLES)) u_stretch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (settle_load),
    .busy    (settle_busy)
  );

  // A word strobe counts only while loading; out-of-range words are dropped.
  assign accept = (state == S_LOAD) && ioctl_wr;
  assign wr_ok  = accept && in_rom(ioctl_addr);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_SETTLE;
    else          state <= next_state;
  end

  // Next-state logic and settle-counter reload requests.
  always_comb begin
    next_state  = state;
    settle_load = 1'b0;
    case (state)
      S_SETTLE: begin
        if (ioctl_download) begin
          next_state = S_ENTER;
        end else if (user_reset) begin
          settle_load = 1'b1;
        end else if (!settle_busy) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (ioctl_download) begin
          next_state = S_ENTER;
        end else if (user_reset) begin
          next_state  = S_SETTLE;
          settle_load = 1'b1;
        end
      end
      S_ENTER: next_state = S_LOAD;
      S_LOAD:  if (!ioctl_download) next_state = S_DRAIN;
      S_DRAIN: begin
        next_state  = S_SETTLE;
        settle_load = 1'b1;
      end
      default: next_state = S_SETTLE;
    endcase
  end

  // Registered outputs, capture register and download status.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reset  <= 1'b1;
      ioctl_wait <= 1'b0;
      rom_we     <= 1'b0;
      cap_addr   <= '0;
      rom_wdata  <= '0;
      load_done  <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      cpu_reset  <= (next_state != S_RUN);
      ioctl_wait <= (next_state == S_ENTER);
      // rom_we doubles as the capture-valid flag: one pulse per stored word.
      rom_we     <= wr_ok;
      if (wr_ok) begin
        cap_addr  <= ioctl_addr[ADDR_W:1];
        rom_wdata <= DATA_W'(ioctl_dout);
      end
      if (state == S_DRAIN) load_done <= 1'b1;
      if (next_state == S_ENTER) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (wr_ok && (word_count != 16'hFFFF)) word_count <= word_count + 16'd1;
        if (accept && !in_rom(ioctl_addr))     overflow   <= 1'b1;
      end
    end
  end

  // The CPU owns the ROM port only while running.
  assign rom_addr    = (state == S_RUN) ? cpu_pc : cap_addr;
  assign instruction = (state == S_RUN) ? rom_rdata : '0;
  assign state_dbg   = state;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: ROM writes go through an expected
// queue checked by a monitor; status and timing are checked inline.
module tb_hack_boot_loader;
  import hack_pkg::*;

  localparam int SETTLE = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [14:0] cpu_pc;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic [14:0] rom_addr;
  logic        rom_we;
  logic [15:0] rom_wdata;
  logic [15:0] rom_rdata;
  logic        load_done;
  logic [15:0] word_count;
  logic        overflow;
  boot_state_t state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [30:0] exp_q[$];
  logic [15:0] mem [0:32767];

  hack_boot_loader #(.ADDR_W(15), .DATA_W(16), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .user_reset     (user_reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cpu_pc         (cpu_pc),
    .instruction    (instruction),
    .cpu_reset      (cpu_reset),
    .rom_addr       (rom_addr),
    .rom_we         (rom_we),
    .rom_wdata      (rom_wdata),
    .rom_rdata      (rom_rdata),
    .load_done      (load_done),
    .word_count     (word_count),
    .overflow       (overflow),
    .state_dbg      (state_dbg)
  );

  // Clock.
  always #5 clk_sys = ~clk_sys;

  // Program store model: combinational read, synchronous write.
  assign rom_rdata = mem[rom_addr];
  always @(posedge clk_sys) if (rom_we) mem[rom_addr] <= rom_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Called in the first S_SETTLE cycle with a freshly loaded counter.
  task automatic expect_release(input string name);
    for (int i = 1; i < SETTLE; i++) tick();
    check({name, "_held"}, 32'(cpu_reset), 32'd1);
    tick();
    check({name, "_released"}, 32'(cpu_reset), 32'd0);
    check({name, "_run"}, 32'(state_dbg), 32'(S_RUN));
  endtask

  task automatic enter_load(input string name);
    ioctl_download = 1'b1;
    tick();
    check({name, "_enter"}, 32'(state_dbg), 32'(S_ENTER));
    check({name, "_wait"}, 32'(ioctl_wait), 32'd1);
    check({name, "_enter_rst"}, 32'(cpu_reset), 32'd1);
    check({name, "_wc_clr"}, 32'(word_count), 32'd0);
    check({name, "_ovf_clr"}, 32'(overflow), 32'd0);
    tick();
    check({name, "_load"}, 32'(state_dbg), 32'(S_LOAD));
    check({name, "_wait_lo"}, 32'(ioctl_wait), 32'd0);
  endtask

  // Drive one word strobe; the expected write is queued only if it should land.
  task automatic put_word(input logic [24:0] a, input logic [15:0] d, input bit lands);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (lands) exp_q.push_back({a[15:1], d});
    tick();
  endtask

  // Scoreboard monitor: every ROM write must match the next expected one.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", rom_addr, rom_wdata);
      end else begin
        check("rom_write", {17'd0, rom_addr, rom_wdata}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [15:0] prog [4];

  initial begin
    prog[0] = 16'h0010; prog[1] = 16'hEC10; prog[2] = 16'h0003; prog[3] = 16'hE308;
    mem[5]         = 16'h1234;
    reset_n        = 1'b0;
    user_reset     = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    cpu_pc         = 15'h0005;
    repeat (3) tick();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_SETTLE));

    // Power-up hold.
    reset_n = 1'b1;
    expect_release("powerup");
    check("run_rom_addr", 32'(rom_addr), 32'h5);
    check("run_instruction", 32'(instruction), 32'h1234);

    // Four back-to-back words.
    enter_load("dl1");
    for (int i = 0; i < 4; i++) put_word(25'(2 * i), prog[i], 1'b1);
    ioctl_wr = 1'b0;
    check("dl1_instr_forced", 32'(instruction), 32'd0);
    tick();
    ioctl_download = 1'b0;
    tick();
    check("dl1_drain", 32'(state_dbg), 32'(S_DRAIN));
    tick();
    check("dl1_settle", 32'(state_dbg), 32'(S_SETTLE));
    check("dl1_load_done", 32'(load_done), 32'd1);
    check("dl1_word_count", 32'(word_count), 32'd4);
    check("dl1_overflow", 32'(overflow), 32'd0);
    cpu_pc = 15'h0001;
    expect_release("dl1");
    check("dl1_fetch", 32'(instruction), 32'hEC10);

    // Out-of-range word is dropped; bit 0 of the byte address is ignored.
    enter_load("dl2");
    put_word(25'h0000008, 16'h5555, 1'b1);
    put_word(25'h0010000, 16'hBEEF, 1'b0);
    ioctl_wr = 1'b0;
    check("dl2_ovf_set", 32'(overflow), 32'd1);
    check("dl2_wc_hold", 32'(word_count), 32'd1);
    put_word(25'h000000B, 16'h7777, 1'b1);
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    tick();
    tick();
    check("dl2_word_count", 32'(word_count), 32'd2);
    check("dl2_overflow", 32'(overflow), 32'd1);
    expect_release("dl2");

    // Next download clears overflow; user_reset ignored while loading;
    // a strobe in the final load cycle is written during S_DRAIN.
    enter_load("dl3");
    user_reset = 1'b1;
    repeat (3) tick();
    check("dl3_ureset_state", 32'(state_dbg), 32'(S_LOAD));
    check("dl3_ureset_cpu", 32'(cpu_reset), 32'd1);
    user_reset     = 1'b0;
    ioctl_download = 1'b0;
    put_word(25'h000000C, 16'hAAAA, 1'b1);
    ioctl_wr = 1'b0;
    check("dl3_drain", 32'(state_dbg), 32'(S_DRAIN));
    check("dl3_drain_we", 32'(rom_we), 32'd1);
    tick();
    check("dl3_word_count", 32'(word_count), 32'd1);
    expect_release("dl3");

    // user_reset held 5 cycles in S_RUN.
    user_reset = 1'b1;
    tick();
    check("ureset_settle", 32'(state_dbg), 32'(S_SETTLE));
    repeat (4) tick();
    check("ureset_hold", 32'(cpu_reset), 32'd1);
    user_reset = 1'b0;
    expect_release("ureset");

    // reset_n pulsed mid-download with ioctl_download still high.
    enter_load("dl4");
    put_word(25'h0000010, 16'h0101, 1'b1);
    put_word(25'h0000012, 16'h0202, 1'b1);
    ioctl_wr = 1'b0;
    tick();
    tick();
    check("dl4_wc_pre", 32'(word_count), 32'd2);
    reset_n = 1'b0;
    #1;
    check("dl4_rst_wc", 32'(word_count), 32'd0);
    check("dl4_rst_done", 32'(load_done), 32'd0);
    check("dl4_rst_cpu", 32'(cpu_reset), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check("dl4_reenter", 32'(state_dbg), 32'(S_ENTER));
    check("dl4_reenter_wc", 32'(word_count), 32'd0);
    tick();
    put_word(25'h0000014, 16'h0303, 1'b1);
    ioctl_wr = 1'b0;
    tick();
    check("dl4_wc", 32'(word_count), 32'd1);
    check("dl4_done_lo", 32'(load_done), 32'd0);
    ioctl_download = 1'b0;
    tick();
    tick();
    check("dl4_done_hi", 32'(load_done), 32'd1);
    expect_release("dl4");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
